// File: rtl/lsu_mem_arbiter_if.sv
// Port bundle of lsu_mem_arbiter: two word-wide master ports, the shared memory port
// and the debug grant vector. The slave modport is the arbiter's view.
interface lsu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              m0_req_i;
    logic              m0_we_i;
    logic [BE_W-1:0]   m0_be_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wd_i;
    logic [DATA_W-1:0] m0_rd_o;
    logic              m0_ready_o;
    logic              m0_err_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [BE_W-1:0]   m1_be_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wd_i;
    logic [DATA_W-1:0] m1_rd_o;
    logic              m1_ready_o;
    logic              m1_err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wd_o;
    logic [DATA_W-1:0] mem_rd_i;
    logic              mem_ready_i;
    logic [1:0]        grant_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
        output m0_rd_o, m0_ready_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
        output m1_rd_o, m1_ready_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i,
        output grant_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
        input  m0_rd_o, m0_ready_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
        input  m1_rd_o, m1_ready_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i,
        input  grant_o
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Two-master data-memory arbiter (LSU + debug/DMA loader) with round-robin or fixed
// priority, grant held until completion and a per-access no-acknowledge watchdog.
module lsu_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    lsu_mem_arbiter_if.slave bus
);
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam bit              RR_ON   = (RR_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              ptr_r;        // last master served
    logic              ptr_nxt_s;
    logic [WD_W-1:0]   wdog_r;
    logic [WD_W-1:0]   wdog_nxt_s;
    logic              own_req_s;
    logic              done_s;
    logic              err_s;
    logic [DATA_W-1:0] rd_pass_s;

    assign own_req_s    = (state_r == ST_OWN1) ? bus.m1_req_i : bus.m0_req_i;
    assign bus.grant_o  = {state_r == ST_OWN1, state_r == ST_OWN0};

    // State, last-served pointer and watchdog registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            ptr_r   <= 1'b1;
            wdog_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            wdog_r  <= wdog_nxt_s;
        end
    end

    // Arbitration, completion and watchdog next-state logic
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        wdog_nxt_s  = wdog_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wdog_nxt_s = '0;
                if (bus.m0_req_i && bus.m1_req_i) begin
                    if (RR_ON && (ptr_r == 1'b0)) begin
                        state_nxt_s = ST_OWN1;
                    end else begin
                        state_nxt_s = ST_OWN0;
                    end
                end else if (bus.m0_req_i) begin
                    state_nxt_s = ST_OWN0;
                end else if (bus.m1_req_i) begin
                    state_nxt_s = ST_OWN1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req_s) begin
                    // abort: pointer untouched so the other master keeps its turn
                    state_nxt_s = ST_IDLE;
                    wdog_nxt_s  = '0;
                end else if (bus.mem_ready_i) begin
                    done_s      = 1'b1;
                    ptr_nxt_s   = (state_r == ST_OWN1);
                    state_nxt_s = ST_IDLE;
                    wdog_nxt_s  = '0;
                end else if (WD_EN && (wdog_r == WD_LAST)) begin
                    done_s      = 1'b1;
                    err_s       = 1'b1;
                    ptr_nxt_s   = (state_r == ST_OWN1);
                    state_nxt_s = ST_IDLE;
                    wdog_nxt_s  = '0;
                end else begin
                    wdog_nxt_s = wdog_r + WD_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wdog_nxt_s  = '0;
            end
        endcase
    end

    // Read data passes straight through, only on a normal completion
    always_comb begin
        if (done_s && !err_s) begin
            rd_pass_s = bus.mem_rd_i;
        end else begin
            rd_pass_s = '0;
        end
    end

    // Memory port steering and master responses; silenced while reset is asserted
    always_comb begin
        bus.mem_req_o  = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_be_o   = '0;
        bus.mem_addr_o = '0;
        bus.mem_wd_o   = '0;
        bus.m0_ready_o = 1'b0;
        bus.m0_err_o   = 1'b0;
        bus.m0_rd_o    = '0;
        bus.m1_ready_o = 1'b0;
        bus.m1_err_o   = 1'b0;
        bus.m1_rd_o    = '0;
        if (!rst_i && (state_r == ST_OWN0)) begin
            bus.mem_req_o  = bus.m0_req_i;
            bus.mem_we_o   = bus.m0_we_i;
            bus.mem_be_o   = bus.m0_be_i;
            bus.mem_addr_o = bus.m0_addr_i;
            bus.mem_wd_o   = bus.m0_wd_i;
            bus.m0_ready_o = done_s;
            bus.m0_err_o   = err_s;
            bus.m0_rd_o    = rd_pass_s;
        end else if (!rst_i && (state_r == ST_OWN1)) begin
            bus.mem_req_o  = bus.m1_req_i;
            bus.mem_we_o   = bus.m1_we_i;
            bus.mem_be_o   = bus.m1_be_i;
            bus.mem_addr_o = bus.m1_addr_i;
            bus.mem_wd_o   = bus.m1_wd_i;
            bus.m1_ready_o = done_s;
            bus.m1_err_o   = err_s;
            bus.m1_rd_o    = rd_pass_s;
        end else begin
            bus.mem_req_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Randomized scoreboard bench for lsu_mem_arbiter: the memory model acknowledges each access
// in the OWN cycle encoded in address bits [20:16] (value+1), so outcomes follow from the address.
module tb_lsu_mem_arbiter;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    logic fp_rst;
    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    lsu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fp_bus ();

    lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
    lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(TIMEOUT)) dut_fp (
        .clk_i(clk), .rst_i(fp_rst), .bus(fp_bus));

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          ncyc;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hCAFE_F00D;
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        return int'(a[20:16]) + 1;
    endfunction

    function automatic logic [31:0] mk_addr(input int k);
        logic [31:0] r;
        r        = $urandom & 32'hFFE0_FFFC;
        r[20:16] = 5'(k - 1);
        return r;
    endfunction

    // Memory model: ack in the k-th cycle of an access, noise on rd/ready otherwise
    int own_cyc = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (rst) begin
            own_cyc         = 0;
            bus.mem_ready_i = 1'b1;
            bus.mem_rd_i    = 32'hDEAD_BEEF;
        end else if (bus.mem_req_o) begin
            own_cyc++;
            if (own_cyc == lat_of(bus.mem_addr_o)) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_rd_i    = mem_data(bus.mem_addr_o);
            end else begin
                bus.mem_ready_i = 1'b0;
                bus.mem_rd_i    = $urandom;
            end
        end else begin
            own_cyc         = 0;
            bus.mem_ready_i = 1'($urandom_range(0, 1));
            bus.mem_rd_i    = $urandom;
        end
    end

    task automatic check_done(input int m, input logic [31:0] rd, input logic err, input int ncyc);
        exp_t e;
        int   sz;
        sz = (m == 0) ? exp_q0.size() : exp_q1.size();
        chk($sformatf("m%0d_ready_expected", m), 64'(sz != 0), 64'(1));
        if (sz != 0) begin
            if (m == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk($sformatf("m%0d_rd", m), 64'(rd), 64'(e.rd));
            chk($sformatf("m%0d_err", m), 64'(err), 64'(e.err));
            chk($sformatf("m%0d_latency", m), 64'(ncyc), 64'(e.ncyc));
        end
    endtask

    // Monitor: invariants, arbitration model, bus steering and response scoreboard
    logic [1:0] g, rdy, req, want;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] prev_req   = 2'b00;
    logic [1:0] prev_rdy   = 2'b00;
    logic       prev_rst   = 1'b1;
    logic       last_served = 1'b1;
    int         own_cnt = 0;
    initial forever begin
        @(negedge clk);
        g   = bus.grant_o;
        rdy = {bus.m1_ready_o, bus.m0_ready_o};
        req = {bus.m1_req_i, bus.m0_req_i};
        if (rst) begin
            chk("ready_in_reset", 64'(rdy), 64'(0));
            last_served = 1'b1;
            own_cnt     = 0;
            prev_grant  = 2'b00;
            prev_req    = 2'b00;
            prev_rdy    = 2'b00;
            prev_rst    = 1'b1;
        end else begin
            chk("grant_onehot0", 64'($onehot0(g)), 64'(1));
            chk("single_ready", 64'(rdy == 2'b11), 64'(0));
            if (bus.mem_req_o) chk("req_has_grant", 64'(g != 2'b00), 64'(1));
            if (prev_rdy != 2'b00) chk("idle_bubble", 64'(g), 64'(0));
            if (prev_grant != 2'b00 && g != 2'b00) chk("owner_stable", 64'(g), 64'(prev_grant));
            if (prev_grant == 2'b00 && !prev_rst) begin
                if (prev_req == 2'b11) want = last_served ? 2'b01 : 2'b10;
                else                   want = prev_req;
                chk("arb_grant", 64'(g), 64'(want));
            end
            own_cnt = (g != 2'b00) ? own_cnt + 1 : 0;
            if (g == 2'b01) begin
                chk("m0_mem_req", 64'(bus.mem_req_o), 64'(bus.m0_req_i));
                chk("m0_mem_ctl", 64'({bus.mem_we_o, bus.mem_be_o}), 64'({bus.m0_we_i, bus.m0_be_i}));
                chk("m0_mem_addr", 64'(bus.mem_addr_o), 64'(bus.m0_addr_i));
                chk("m0_mem_wd", 64'(bus.mem_wd_o), 64'(bus.m0_wd_i));
                chk("m1_quiet", 64'({bus.m1_ready_o, bus.m1_err_o}), 64'(0));
            end else if (g == 2'b10) begin
                chk("m1_mem_req", 64'(bus.mem_req_o), 64'(bus.m1_req_i));
                chk("m1_mem_ctl", 64'({bus.mem_we_o, bus.mem_be_o}), 64'({bus.m1_we_i, bus.m1_be_i}));
                chk("m1_mem_addr", 64'(bus.mem_addr_o), 64'(bus.m1_addr_i));
                chk("m1_mem_wd", 64'(bus.mem_wd_o), 64'(bus.m1_wd_i));
                chk("m0_quiet", 64'({bus.m0_ready_o, bus.m0_err_o}), 64'(0));
            end else begin
                chk("idle_mem_ctl", 64'({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}), 64'(0));
                chk("idle_mem_addr", 64'(bus.mem_addr_o), 64'(0));
                chk("idle_mem_wd", 64'(bus.mem_wd_o), 64'(0));
                chk("idle_ready", 64'(rdy), 64'(0));
            end
            if (rdy[0]) begin
                check_done(0, bus.m0_rd_o, bus.m0_err_o, own_cnt);
                last_served = 1'b0;
            end else begin
                chk("m0_idle_rd_err", 64'({bus.m0_err_o, bus.m0_rd_o}), 64'(0));
            end
            if (rdy[1]) begin
                check_done(1, bus.m1_rd_o, bus.m1_err_o, own_cnt);
                last_served = 1'b1;
            end else begin
                chk("m1_idle_rd_err", 64'({bus.m1_err_o, bus.m1_rd_o}), 64'(0));
            end
            prev_grant = g;
            prev_req   = req;
            prev_rdy   = rdy;
            prev_rst   = 1'b0;
        end
    end

    // Issue one access, push its expected outcome, hold req until the ready pulse
    task automatic do_txn(input int m, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   k;
        int   waited;
        logic got;
        k      = lat_of(addr);
        e.err  = (k > TIMEOUT);
        e.rd   = e.err ? 32'h0 : mem_data(addr);
        e.ncyc = e.err ? TIMEOUT : k;
        if (m == 0) begin
            exp_q0.push_back(e);
            bus.m0_we_i = we; bus.m0_be_i = be; bus.m0_addr_i = addr; bus.m0_wd_i = wd;
            bus.m0_req_i = 1'b1;
        end else begin
            exp_q1.push_back(e);
            bus.m1_we_i = we; bus.m1_be_i = be; bus.m1_addr_i = addr; bus.m1_wd_i = wd;
            bus.m1_req_i = 1'b1;
        end
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            got = (m == 0) ? bus.m0_ready_o : bus.m1_ready_o;
        end
        chk($sformatf("m%0d_done_in_bound", m), 64'(got), 64'(1));
        @(posedge clk);
        #1;
        if (m == 0) bus.m0_req_i = 1'b0;
        else        bus.m1_req_i = 1'b0;
    endtask

    task automatic run_master(input int m, input int n);
        int k;
        int gap;
        for (int i = 0; i < n; i++) begin
            if (m == 0 && i == 0)      k = 2;
            else if (m == 0 && i == 1) k = TIMEOUT;
            else if (m == 0 && i == 2) k = TIMEOUT + 1;
            else                       k = $urandom_range(1, 20);
            do_txn(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), mk_addr(k), $urandom);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    // Fixed-priority instance: both masters always requesting, memory always ready
    task automatic fp_check();
        int m0n;
        int m1n;
        int g1n;
        m0n = 0; m1n = 0; g1n = 0;
        repeat (20) begin
            @(negedge clk);
            m0n += int'(fp_bus.m0_ready_o);
            m1n += int'(fp_bus.m1_ready_o);
            if (fp_bus.grant_o == 2'b10) g1n++;
            if (fp_bus.m0_ready_o) chk("fp_m0_rd", 64'(fp_bus.m0_rd_o), 64'(32'h5A5A_1234));
        end
        chk("fp_m0_completions", 64'(m0n), 64'(10));
        chk("fp_m1_completions", 64'(m1n), 64'(0));
        chk("fp_m1_grants", 64'(g1n), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int waited;
        rst = 1'b1; fp_rst = 1'b1;
        bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_be_i = 4'h0; bus.m0_addr_i = 32'h0; bus.m0_wd_i = 32'h0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_be_i = 4'h0; bus.m1_addr_i = 32'h0; bus.m1_wd_i = 32'h0;
        bus.mem_ready_i = 1'b0; bus.mem_rd_i = 32'h0;
        fp_bus.m0_req_i = 1'b1; fp_bus.m0_we_i = 1'b0; fp_bus.m0_be_i = 4'hF;
        fp_bus.m0_addr_i = 32'h40; fp_bus.m0_wd_i = 32'h0;
        fp_bus.m1_req_i = 1'b1; fp_bus.m1_we_i = 1'b1; fp_bus.m1_be_i = 4'hF;
        fp_bus.m1_addr_i = 32'h80; fp_bus.m1_wd_i = 32'h1111_2222;
        fp_bus.mem_ready_i = 1'b1; fp_bus.mem_rd_i = 32'h5A5A_1234;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(bus.grant_o), 64'(0));
        chk("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
        chk("rst_fp_grant", 64'(fp_bus.grant_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0; fp_rst = 1'b0;

        fork
            run_master(0, 40);
            run_master(1, 40);
            fp_check();
        join
        chk("q0_drained", 64'(exp_q0.size()), 64'(0));
        chk("q1_drained", 64'(exp_q1.size()), 64'(0));

        // reset while m1 owns the bus, memory acking in that very cycle
        @(posedge clk);
        #1;
        bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h0001_0000; bus.m1_req_i = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.grant_o != 2'b10 && waited < 10);
        chk("t6_m1_granted", 64'(bus.grant_o), 64'(2'b10));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.m1_req_i = 1'b0;
        @(negedge clk);
        chk("t6_grant", 64'(bus.grant_o), 64'(0));
        chk("t6_mem_req", 64'(bus.mem_req_o), 64'(0));
        chk("t6_ready", 64'({bus.m0_ready_o, bus.m1_ready_o, bus.m0_err_o, bus.m1_err_o}), 64'(0));
        chk("t6_rd", 64'({bus.m0_rd_o, bus.m1_rd_o}), 64'(0));

        // tie after reset goes to m0; m1 then performs the byte-masked write
        @(posedge clk);
        #1;
        fork
            do_txn(0, 1'b0, 4'hF, 32'h0001_0100, 32'h0);
            do_txn(1, 1'b1, 4'b0011, 32'h0000_0020, 32'h0000_1234);
        join
        chk("q0_drained_end", 64'(exp_q0.size()), 64'(0));
        chk("q1_drained_end", 64'(exp_q1.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
